// File: rtl/spi_ram_ctrl.sv
// Byte RAM behind an SPI slave: decodes 2-bit opcodes from the rx word stream and returns read data.
// Optional SPI_RAM_AUTO_INC_EN: post-increment wr_addr on writes and rd_addr on reads.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 rx_valid_q;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 acc;
  logic                 mem_we;

  // One command per rising edge of rx_valid, however long it stays high.
  assign acc = rx_valid & ~rx_valid_q;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    mem_we     = 1'b0;
    if (!rx_valid) tx_valid_d = 1'b0;
    if (acc) begin
      case (din[9:8])
        2'b00: begin
          wr_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        2'b01: begin
          mem_we     = 1'b1;
          tx_valid_d = 1'b0;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_addr_d  = wr_addr_q + ADDR_SIZE'(1);
`endif
        end
        2'b10: begin
          rd_addr_d  = din[ADDR_SIZE-1:0];
          tx_valid_d = 1'b0;
        end
        default: begin
          dout_d     = mem[rd_addr_q];
          tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rx_valid_q <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rx_valid_q <= rx_valid;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= din[7:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: a byte-array model predicts every read response.
module tb_spi_ram_ctrl;
  logic       clk, rst, rx_valid, tx_valid;
  logic [9:0] din;
  logic [7:0] dout;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0;
  logic [7:0] m_mem [256];
  logic [7:0] m_wa, m_ra;
  logic [7:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: command semantics as plain byte arithmetic.
  task automatic model(input logic [9:0] w);
    case (w[9:8])
      2'd0: m_wa = w[7:0];
      2'd1: begin
        m_mem[m_wa] = w[7:0];
`ifdef SPI_RAM_AUTO_INC_EN
        m_wa = m_wa + 8'd1;
`endif
      end
      2'd2: m_ra = w[7:0];
      default: begin
        sb.push_back(m_mem[m_ra]);
`ifdef SPI_RAM_AUTO_INC_EN
        m_ra = m_ra + 8'd1;
`endif
      end
    endcase
  endtask

  // Called at a falling edge; leaves at a falling edge with rx_valid low for gap cycles.
  task automatic send(input logic [9:0] w, input int hold, input int gap);
    din = w;
    rx_valid = 1'b1;
    model(w);
    repeat (hold) begin
      @(negedge clk);
      if (w[9:8] == 2'd3) chk("tx_valid_during_read", tx_valid, 1'b1);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    chk("tx_valid_after_fall", tx_valid, 1'b0);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic rsend(input logic [9:0] w);
    send(w, $urandom_range(1, 4), $urandom_range(1, 2));
  endtask

  // Monitor: each new tx_valid assertion consumes one predicted read byte.
  logic tx_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) tx_prev = 1'b0;
    else begin
      if (tx_valid && !tx_prev) begin
        if (sb.size() == 0) chk("unexpected_tx_valid", 1, 0);
        else chk("read_data", dout, sb.pop_front());
      end
      tx_prev = tx_valid;
    end
  end

  initial begin
    rst = 1; rx_valid = 0; din = '0;
    m_wa = 0; m_ra = 0;
    #3;
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_dout", dout, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int a = 0; a < 256; a++) begin
      rsend(10'(a));
      rsend({2'd1, 8'($urandom)});
    end

    // basic write/read, single-cycle pulses and one-cycle gaps
    send(10'h03A, 1, 1); send(10'h1C5, 1, 1); send(10'h23A, 1, 1); send(10'h300, 3, 1);
    chk("basic_model_c5", m_mem[8'h3A], 8'hC5);

    // held rx_valid writes exactly once
    rsend(10'h010);
    send(10'h155, 12, 2);
    rsend(10'h210); rsend(10'h3AA);
    rsend(10'h211); rsend(10'h3AA);
    rsend(10'h20F); rsend(10'h3AA);

    // auto-increment wrap scenario (result depends on build)
    rsend(10'h0FE); rsend(10'h111); rsend(10'h122); rsend(10'h133);
    rsend(10'h2FE); rsend(10'h300); rsend(10'h300); rsend(10'h300);
    rsend(10'h2FF); rsend(10'h300);
    rsend(10'h200); rsend(10'h300);

    for (int i = 0; i < 300; i++) rsend(10'($urandom));

    // reset mid-read, with the next read word already held at release
    rsend(10'h2A0);
    din = 10'h300; rx_valid = 1; model(10'h300);
    @(negedge clk);
    chk("pre_reset_tx_valid", tx_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_reset_tx_valid", tx_valid, 0);
    chk("async_reset_dout", dout, 0);
    m_wa = 0; m_ra = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    model(10'h300);
    @(negedge clk);
    chk("held_at_release_tx_valid", tx_valid, 1);
    rx_valid = 0;
    @(negedge clk);
    chk("held_at_release_fall", tx_valid, 0);
    rsend(10'h23A); rsend(10'h300);
    rsend(10'h210); rsend(10'h300);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Single-port byte memory with command decoder, sitting directly downstream of the SPI slave. Consumes the slave's 10-bit `rx_data`/`rx_valid` word stream, treats the top two bits as an opcode (set write address, write data, set read address, read data), and returns read bytes to the slave on `dout`/`tx_valid` for shifting out on MISO. Memory contents are not reset; only control state is.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words.
- `ADDR_SIZE`, 8: address width; must satisfy 2^ADDR_SIZE = MEM_DEPTH and ADDR_SIZE <= 8.

- `clk` in 1: clock; everything is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `din` in 10: word from the SPI slave's `rx_data`; `din[9:8]` is the opcode and `din[7:0]` is the payload.
- `rx_valid` in 1: word-valid from the SPI slave. May stay high for many cycles per word.
- `dout` out 8: read data to the slave's `tx_data`.
- `tx_valid` out 1: `dout` holds valid read data.

## Operation
- Accept pulse: `acc = rx_valid & ~rx_valid_q`, where `rx_valid_q` is `rx_valid` registered.
  - Exactly one command executes per `rx_valid` rising edge.
  - A held-high `rx_valid` never repeats a command.
- Opcodes, acted on at the edge where `acc` = 1:
  - 00: `wr_addr <= din[ADDR_SIZE-1:0]`.
  - 01: `mem[wr_addr] <= din[7:0]`.
  - 10: `rd_addr <= din[ADDR_SIZE-1:0]`.
  - 11: `dout <= mem[rd_addr]`, `tx_valid <= 1`.
- When ADDR_SIZE < 8, the upper payload bits are ignored for addresses.
- The payload of opcode 11 is ignored.
- `tx_valid` clears:
  - on the first cycle in which `rx_valid` is sampled low, or
  - on any accepted command with opcode other than 11.
- After `tx_valid` clears, `dout` holds its last value.
- A second opcode 11 while `tx_valid` = 1 reloads `dout` from the current `rd_addr`; `tx_valid` stays 1.
- Internal registers: `wr_addr`, `rd_addr`, `rx_valid_q`, `dout`, `tx_valid`, and `mem[MEM_DEPTH]`.
- Reset values, applied asynchronously: `dout` = 0, `tx_valid` = 0, `wr_addr` = 0, `rd_addr` = 0, `rx_valid_q` = 0.
- Memory is untouched by reset.
- `rx_valid` already high when `rst` releases: `rx_valid_q` = 0, so the held word is accepted on the first clock after release. This is intended.
- Unlisted conditions: all registers hold.

## Timing
- Write (opcode 01): the memory updates at the same edge that samples `acc` = 1, i.e. 1 cycle after `rx_valid` rises.
- Read (opcode 11): `dout` and `tx_valid` become valid after the edge sampling `acc`.
  - `tx_valid` is visible in the cycle following that edge.
  - Latency is 1 clock from `rx_valid` rising to `tx_valid` high.
- `tx_valid` fall: the edge after `rx_valid` is sampled low.
  - `tx_valid` stays high for at least as long as `rx_valid`, covering the slave's 8-bit shift-out.
- `rx_valid` pulse of exactly 1 cycle: accepted.
- Back-to-back words with `rx_valid` low for 1 cycle between them: both accepted.
- Assertion of `rst` mid-read: `tx_valid` drops immediately (combinationally relative to `rst`, no clock needed).

## Configuration
- `SPI_RAM_AUTO_INC_EN` defined:
  - After each accepted opcode 01, `wr_addr` increments.
  - After each accepted opcode 11, `rd_addr` increments.
  - Both wrap from MEM_DEPTH-1 to 0.
  - Opcodes 00 and 10 still load the address directly.
- Not defined: addresses change only on opcodes 00 and 10. Repeated 01 writes overwrite the same word; repeated 11 reads return the same word.

## Test plan
- Basic write/read:
  - Stimulus: words 0x0_3A (opcode 00, payload 0x3A), then 0x1_C5, then 0x2_3A, then 0x3_00.
  - Required: `mem[0x3A]` = 0xC5; `dout` = 0xC5 with `tx_valid` = 1 one cycle after the last `rx_valid` rise.
  - Required: `tx_valid` = 0 one cycle after `rx_valid` falls.
- Held `rx_valid`:
  - Stimulus: set address 0x10, then hold `rx_valid` high for 12 cycles with `din` = 0x1_55.
  - Required: exactly one write (`mem[0x10]` = 0x55); no other location changes.
- Auto-increment (macro defined):
  - Stimulus: 0x0_FE, then data words 0x1_11, 0x1_22, 0x1_33.
  - Required: `mem[0xFE]` = 0x11, `mem[0xFF]` = 0x22, `mem[0x00]` = 0x33.
  - Required: reads from 0xFE return 0x11, then 0x22, then 0x33.
- Auto-increment off (macro undefined), same stimulus:
  - Required: `mem[0xFE]` = 0x33; `mem[0xFF]` and `mem[0x00]` unchanged.
- Reset mid-read:
  - Stimulus: assert `rst` while `tx_valid` = 1.
  - Required: `tx_valid` = 0 and `dout` = 0 without a clock edge.
  - Required: after release, a read of a previously written address still returns its data.
